button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 124 ++++++++++++
 tb/tb_button_conditioner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button synchronizer, debouncer and press/hold/auto-repeat event generator
module button_conditioner #(
  parameter int CH           = 4,
  parameter int DB_LEN       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STRETCH      = 4,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] btn_in,
  input  logic [CH-1:0] repeat_en,
  output logic [CH-1:0] level,
  output logic [CH-1:0] press,
  output logic [CH-1:0] release_pulse,
  output logic [CH-1:0] press_ext,
  output logic [CH-1:0] long_press,
  output logic [CH-1:0] repeat_pulse
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(STRETCH + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH);
  localparam logic [HW-1:0] HOLD_FULL    = HW'(HOLD_TICKS);
  localparam logic [RW-1:0] REP_LAST     = RW'(REPEAT_TICKS - 1);

  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [CH-1:0]     sync1;
  logic [CH-1:0]     sync2;
  logic [DB_LEN-1:0] hist        [CH];
  logic [DB_LEN-1:0] hist_next   [CH];
  logic [CH-1:0]     level_next;
  logic [SW-1:0]     stretch_cnt [CH];
  logic [HW-1:0]     hold_cnt    [CH];
  logic [RW-1:0]     rep_cnt     [CH];

  assign tick = (tick_cnt == TICK_LAST);

  // Level moves only on a tick, and only when the whole updated history agrees.
  always_comb begin
    level_next = level;
    for (int i = 0; i < CH; i++) begin
      hist_next[i] = {hist[i][DB_LEN-2:0], sync2[i]};
      if (tick && (&hist_next[i])) begin
        level_next[i] = 1'b1;
      end else if (tick && !(|hist_next[i])) begin
        level_next[i] = 1'b0;
      end
    end
  end

  always_comb begin
    press_ext = '0;
    for (int i = 0; i < CH; i++) begin
      press_ext[i] = (stretch_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt      <= '0;
      sync1         <= '0;
      sync2         <= '0;
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      long_press    <= '0;
      repeat_pulse  <= '0;
      for (int i = 0; i < CH; i++) begin
        hist[i]        <= '0;
        stretch_cnt[i] <= '0;
        hold_cnt[i]    <= '0;
        rep_cnt[i]     <= '0;
      end
    end else begin
      tick_cnt      <= tick ? '0 : tick_cnt + TW'(1);
      sync1         <= btn_in;
      sync2         <= sync1;
      level         <= level_next;
      press         <= level_next & ~level;
      release_pulse <= ~level_next & level;
      long_press    <= '0;
      repeat_pulse  <= '0;
      for (int i = 0; i < CH; i++) begin
        if (tick) begin
          hist[i] <= hist_next[i];
        end

        if (level_next[i] && !level[i]) begin
          stretch_cnt[i] <= STRETCH_LOAD;
        end else if (stretch_cnt[i] != '0) begin
          stretch_cnt[i] <= stretch_cnt[i] - SW'(1);
        end

        // The rising tick itself counts toward the hold; saturation gives one long_press per hold.
        if (!level_next[i]) begin
          hold_cnt[i] <= '0;
        end else if (tick && (hold_cnt[i] != HOLD_FULL)) begin
          hold_cnt[i]   <= hold_cnt[i] + HW'(1);
          long_press[i] <= (hold_cnt[i] == HOLD_FULL - HW'(1));
        end

        // Counting starts only on ticks after saturation, so repeat never lands on the long_press tick.
        if (!level_next[i] || !repeat_en[i]) begin
          rep_cnt[i] <= '0;
        end else if (tick && (hold_cnt[i] == HOLD_FULL)) begin
          if (rep_cnt[i] == REP_LAST) begin
            rep_cnt[i]      <= '0;
            repeat_pulse[i] <= 1'b1;
          end else begin
            rep_cnt[i] <= rep_cnt[i] + RW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

  localparam int CH           = 2;
  localparam int DB_LEN       = 3;
  localparam int TICK_DIV     = 4;
  localparam int STRETCH      = 3;
  localparam int HOLD_TICKS   = 5;
  localparam int REPEAT_TICKS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] level;
  logic [CH-1:0] press;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] press_ext;
  logic [CH-1:0] long_press;
  logic [CH-1:0] repeat_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .CH(CH), .DB_LEN(DB_LEN), .TICK_DIV(TICK_DIV), .STRETCH(STRETCH),
    .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
    .level(level), .press(press), .release_pulse(release_pulse),
    .press_ext(press_ext), .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  // Reference model: run lengths of equal samples instead of a history register.
  int            m_cnt;
  bit            m_tick;
  bit            m_p1 [CH];
  bit            m_p2 [CH];
  int            ones_run [CH];
  int            zeros_run [CH];
  int            m_hold [CH];
  int            m_rep [CH];
  int            m_str [CH];
  logic [CH-1:0] e_level, e_press, e_rel, e_ext, e_long, e_rep;

  always @(posedge clk) begin : model
    bit samp, nl, full_before;
    if (!rst) begin
      m_cnt = 0; m_tick = 0;
      e_level = '0; e_press = '0; e_rel = '0; e_ext = '0; e_long = '0; e_rep = '0;
      for (int c = 0; c < CH; c++) begin
        m_p1[c] = 0; m_p2[c] = 0; ones_run[c] = 0; zeros_run[c] = 0;
        m_hold[c] = 0; m_rep[c] = 0; m_str[c] = 0;
      end
    end else begin
      m_tick = (m_cnt == TICK_DIV - 1);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      for (int c = 0; c < CH; c++) begin
        samp = m_p2[c]; m_p2[c] = m_p1[c]; m_p1[c] = btn_in[c];
        nl = e_level[c];
        full_before = (m_hold[c] == HOLD_TICKS);
        e_long[c] = 0; e_rep[c] = 0;
        if (m_tick) begin
          if (samp) begin ones_run[c]++; zeros_run[c] = 0; end
          else begin zeros_run[c]++; ones_run[c] = 0; end
          if (ones_run[c] >= DB_LEN) nl = 1;
          else if (zeros_run[c] >= DB_LEN) nl = 0;
        end
        e_press[c] = nl && !e_level[c];
        e_rel[c]   = !nl && e_level[c];
        if (e_press[c]) m_str[c] = STRETCH;
        else if (m_str[c] > 0) m_str[c]--;
        if (!nl) m_hold[c] = 0;
        else if (m_tick && m_hold[c] < HOLD_TICKS) begin
          m_hold[c]++;
          e_long[c] = (m_hold[c] == HOLD_TICKS);
        end
        if (!nl || !repeat_en[c]) m_rep[c] = 0;
        else if (m_tick && full_before) begin
          m_rep[c]++;
          if (m_rep[c] == REPEAT_TICKS) begin e_rep[c] = 1; m_rep[c] = 0; end
        end
        e_level[c] = nl;
        e_ext[c]   = (m_str[c] != 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("model_level",      32'(level),         32'(e_level));
    chk("model_press",      32'(press),         32'(e_press));
    chk("model_release",    32'(release_pulse), 32'(e_rel));
    chk("model_press_ext",  32'(press_ext),     32'(e_ext));
    chk("model_long_press", 32'(long_press),    32'(e_long));
    chk("model_repeat",     32'(repeat_pulse),  32'(e_rep));
  endtask

  task automatic tick_step();
    int n = 0;
    do begin step(); n++; end while (!m_tick && n < TICK_DIV + 2);
    chk("tick_bound", 32'(m_tick), 32'd1);
  endtask

  initial begin
    int tcount, rise, k, press_cycles, ext_cycles, long_k, cnt, tz, rel_tz;
    int h_at, r_at, changes, pulses, long_seen, repress, both_seen, pseen, len;
    bit start;
    int rep_ks[$];

    rst = 1'b0; btn_in = 2'b01; repeat_en = 2'b01;
    repeat (3) step();
    chk("reset_outputs", 32'({level, press, release_pulse, press_ext, long_press, repeat_pulse}), 32'd0);
    rst = 1'b1;

    // Held from reset release: rise, press width, stretch, long press and repeats.
    tcount = 0; rise = 0; k = 0; press_cycles = 0; ext_cycles = 0; long_k = -1;
    for (int cy = 0; cy < 80 && k < 11; cy++) begin
      step();
      if (m_tick) tcount++;
      if (level[0] && rise == 0) rise = tcount;
      if (rise != 0 && m_tick) k = tcount - rise + 1;
      if (press[0]) press_cycles++;
      if (press_ext[0]) ext_cycles++;
      if (long_press[0]) long_k = k;
      if (repeat_pulse[0]) rep_ks.push_back(k);
    end
    chk("rise_tick", rise, 3);
    chk("press_width", press_cycles, 1);
    chk("press_ext_width", ext_cycles, 3);
    chk("long_press_tick", long_k, 5);
    chk("repeat_count", rep_ks.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < rep_ks.size()) chk("repeat_tick", rep_ks[i], 7 + 2 * i);

    repeat_en = 2'b00; cnt = 0;
    repeat (6) begin tick_step(); if (repeat_pulse[0]) cnt++; end
    chk("repeat_after_disable", cnt, 0);
    chk("level_still_high", 32'(level[0]), 32'd1);

    // Release after a hold with repeat running.
    repeat_en = 2'b01;
    repeat (3) tick_step();
    btn_in = 2'b00; tz = 0; rel_tz = -1; h_at = -1; r_at = -1;
    repeat (6) begin
      tick_step(); tz++;
      if (release_pulse[0] && rel_tz < 0) begin
        rel_tz = tz; h_at = 32'(dut.hold_cnt[0]); r_at = 32'(dut.rep_cnt[0]);
      end
    end
    chk("release_tick", rel_tz, 3);
    chk("hold_cnt_cleared", h_at, 0);
    chk("rep_cnt_cleared", r_at, 0);

    // Bounce at a low and at a high debounced level.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin btn_in[0] = 1'b1; repeat (4) tick_step(); end
      start = level[0]; changes = 0; pulses = 0;
      chk("bounce_start_level", 32'(start), pass);
      repeat (10) begin
        int n = 0;
        btn_in[0] = ~btn_in[0];
        do begin
          step(); n++;
          if (level[0] != start) changes++;
          if (press[0] || release_pulse[0]) pulses++;
        end while (!m_tick && n < 8);
      end
      chk("bounce_level_changes", changes, 0);
      chk("bounce_pulses", pulses, 0);
    end

    // Reset on the cycle before the long_press tick.
    rst = 1'b0; btn_in = 2'b00; repeat_en = 2'b00;
    repeat (2) step();
    btn_in = 2'b01; rst = 1'b1;
    tcount = 0; rise = 0; k = 0;
    for (int cy = 0; cy < 60 && k < 4; cy++) begin
      step();
      if (m_tick) tcount++;
      if (level[0] && rise == 0) rise = tcount;
      if (rise != 0 && m_tick) k = tcount - rise + 1;
    end
    chk("hold_reached_4", k, 4);
    repeat (TICK_DIV - 1) step();
    rst = 1'b0;
    step();
    chk("reset_clears_all", 32'({level, press, release_pulse, press_ext, long_press, repeat_pulse}), 32'd0);
    long_seen = 0;
    repeat (5) begin step(); if (long_press[0]) long_seen = 1; end
    rst = 1'b1; repress = 0;
    repeat (14) begin
      step();
      if (long_press[0]) long_seen = 1;
      if (press[0]) repress = 1;
    end
    chk("no_long_press_after_reset", long_seen, 0);
    chk("repress_after_reset", repress, 1);

    // Simultaneous presses, then a second press on channel 0.
    rst = 1'b0; btn_in = 2'b00;
    repeat (2) step();
    rst = 1'b1;
    repeat (2) tick_step();
    btn_in = 2'b11; both_seen = 0;
    repeat (20) begin step(); if (press == 2'b11) both_seen++; end
    chk("both_press_same_cycle", both_seen, 1);
    btn_in = 2'b00;
    repeat (5) tick_step();
    btn_in = 2'b01; pseen = 0; ext_cycles = 0;
    repeat (24) begin
      step();
      if (press[0]) pseen = 1;
      if (pseen && press_ext[0]) ext_cycles++;
    end
    chk("second_press_seen", pseen, 1);
    chk("second_press_ext_width", ext_cycles, 3);

    // Random traffic against the model.
    rst = 1'b0; step(); rst = 1'b1;
    for (int s = 0; s < 300; s++) begin
      btn_in = CH'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) repeat_en = CH'($urandom_range(0, 3));
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(40, 90)) : int'($urandom_range(1, 20));
      if ($urandom_range(0, 49) == 0) rst = 1'b0;
      repeat (len) begin step(); rst = 1'b1; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
